// File: rtl/uart_wb_pkg.sv
// Shared types and constants for the UART-to-Wishbone bridge.
//   state_t    : bridge FSM states
//   RSP_ACK    : status byte returned after a successful write
//   RSP_ERR    : status byte returned after a bus timeout
//   CMD_WR_BIT : bit of the command byte that selects write
//   cnt_width  : bits needed to hold a count from 0 to n inclusive
package uart_wb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        BUS,
        RESP
    } state_t;

    localparam logic [7:0] RSP_ACK    = 8'hA5;
    localparam logic [7:0] RSP_ERR    = 8'hEE;
    localparam int         CMD_WR_BIT = 7;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/uart_wb_master_if.sv
// Classic Wishbone single-master bus bundle.
//   master modport : drives adr/dat_o/we/cyc/stb, samples dat_i/ack
//   slave modport  : the mirror image
interface uart_wb_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] wb_adr_o;
    logic [DATA_W-1:0] wb_dat_o;
    logic [DATA_W-1:0] wb_dat_i;
    logic              wb_we_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/uart_wb_tx_ser.sv
// Response serializer: loads a DATA_W word and a byte count, then hands the
// bytes to the UART transmitter MSB first.
//   CLK, RESET_N : clock, synchronous active-low reset
//   start        : load word/count (only asserted while idle)
//   word, count  : response payload, left-aligned, and its byte count
//   tx_data      : byte presented to the transmitter
//   tx_load      : one-cycle load strobe
//   tx_busy      : transmitter busy
//   last         : tx_load of the final byte
module uart_wb_tx_ser #(
    parameter int DATA_W = 16,
    parameter int CW     = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [DATA_W-1:0] word,
    input  logic [CW-1:0]     count,
    output logic [7:0]        tx_data,
    output logic              tx_load,
    input  logic              tx_busy,
    output logic              last
);
    logic [DATA_W-1:0] sr_reg;
    logic [CW-1:0]     cnt_reg;
    logic              load_prev_reg;

    // The transmitter raises tx_busy a cycle after a load, so a load is never
    // issued on the cycle right after another one.
    assign tx_load = (cnt_reg != '0) && !tx_busy && !load_prev_reg;
    assign tx_data = sr_reg[DATA_W-1 -: 8];
    assign last    = tx_load && (cnt_reg == CW'(1));

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sr_reg        <= '0;
            cnt_reg       <= '0;
            load_prev_reg <= 1'b0;
        end else begin
            load_prev_reg <= tx_load;
            if (start) begin
                sr_reg  <= word;
                cnt_reg <= count;
            end else if (tx_load) begin
                sr_reg  <= sr_reg << 8;
                cnt_reg <= cnt_reg - CW'(1);
            end
        end
    end
endmodule

// File: rtl/uart_wb_master.sv
// UART-to-Wishbone bus master. Parses CMD + address (+ data for writes)
// frames arriving byte by byte, runs one classic Wishbone cycle with a
// timeout and returns read data or a status byte through the transmitter.
//   CLK, RESET_N       : clock, synchronous active-low reset
//   rx_data, rx_valid  : received byte and its one-cycle strobe
//   tx_data, tx_load   : byte to send and its one-cycle load strobe
//   tx_busy            : transmitter busy
//   wb                 : Wishbone master port
//   busy               : high whenever the FSM is not idle
//   rx_drop            : sticky, a byte arrived during BUS or RESP
// Optional build macro UART_WB_RX_GAP_EN: abort a partial frame after RX_GAP
// idle cycles between bytes.
module uart_wb_master
    import uart_wb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BUS_TIMEOUT = 255,
    parameter int RX_GAP      = 100000
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_load,
    input  logic                 tx_busy,
    uart_wb_master_if.master     wb,
    output logic                 busy,
    output logic                 rx_drop
);
    localparam int NA = ADDR_W / 8;
    localparam int ND = DATA_W / 8;
    localparam int BW = cnt_width((NA > ND) ? NA : ND);
    localparam int CW = cnt_width(ND);

    state_t            state_reg, state_next;
    logic [BW-1:0]     byte_cnt_reg;
    logic [15:0]       to_cnt_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] adr_reg;
    logic [DATA_W-1:0] dat_reg;
    logic              rx_drop_reg;

    logic              last_addr, last_data, timeout, bus_done, ser_last, gap_hit;
    logic [DATA_W-1:0] rsp_word;
    logic [CW-1:0]     rsp_count;
    logic [ADDR_W+7:0] adr_shift;
    logic [DATA_W+7:0] dat_shift;

    assign last_addr = (byte_cnt_reg == BW'(NA - 1));
    assign last_data = (byte_cnt_reg == BW'(ND - 1));
    assign adr_shift = {adr_reg, rx_data};
    assign dat_shift = {dat_reg, rx_data};

    // An ACK on the timeout cycle takes precedence over the timeout.
    assign timeout  = !wb.wb_ack_i && (to_cnt_reg == 16'(BUS_TIMEOUT - 1));
    assign bus_done = (state_reg == BUS) && (wb.wb_ack_i || timeout);

    // Responses are left-aligned so the serializer always starts at the MSB.
    always_comb begin
        rsp_word  = DATA_W'(RSP_ERR) << (DATA_W - 8);
        rsp_count = CW'(1);
        if (wb.wb_ack_i) begin
            if (we_reg) begin
                rsp_word = DATA_W'(RSP_ACK) << (DATA_W - 8);
            end else begin
                rsp_word  = wb.wb_dat_i;
                rsp_count = CW'(ND);
            end
        end
    end

`ifdef UART_WB_RX_GAP_EN
    logic [31:0] gap_cnt_reg;
    logic        in_frame;

    assign in_frame = (state_reg == ADDR) || (state_reg == WDATA);
    assign gap_hit  = in_frame && !rx_valid && (gap_cnt_reg == 32'(RX_GAP - 1));

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            gap_cnt_reg <= '0;
        end else if (in_frame && !rx_valid && !gap_hit) begin
            gap_cnt_reg <= gap_cnt_reg + 32'd1;
        end else begin
            gap_cnt_reg <= '0;
        end
    end
`else
    // Feature compiled out: constant-false expression keeps RX_GAP referenced.
    assign gap_hit = (RX_GAP < 0);
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (rx_valid) state_next = ADDR;
            ADDR: begin
                if (rx_valid && last_addr) state_next = we_reg ? WDATA : BUS;
                else if (gap_hit)          state_next = IDLE;
            end
            WDATA: begin
                if (rx_valid && last_data) state_next = BUS;
                else if (gap_hit)          state_next = IDLE;
            end
            BUS:     if (bus_done) state_next = RESP;
            RESP:    if (ser_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the state register, so they are glitch-free and
    // change exactly on the edge that enters or leaves BUS.
    always_comb begin
        busy        = (state_reg != IDLE);
        wb.wb_cyc_o = (state_reg == BUS);
        wb.wb_stb_o = (state_reg == BUS);
        wb.wb_we_o  = (state_reg == BUS) && we_reg;
    end

    assign wb.wb_adr_o = adr_reg;
    assign wb.wb_dat_o = dat_reg;
    assign rx_drop     = rx_drop_reg;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            byte_cnt_reg <= '0;
            to_cnt_reg   <= '0;
            we_reg       <= 1'b0;
            adr_reg      <= '0;
            dat_reg      <= '0;
            rx_drop_reg  <= 1'b0;
        end else begin
            if (rx_valid && ((state_reg == BUS) || (state_reg == RESP))) begin
                rx_drop_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    byte_cnt_reg <= '0;
                    to_cnt_reg   <= '0;
                    if (rx_valid) we_reg <= rx_data[CMD_WR_BIT];
                end
                ADDR: begin
                    if (rx_valid) begin
                        adr_reg      <= adr_shift[ADDR_W-1:0];
                        byte_cnt_reg <= last_addr ? '0 : byte_cnt_reg + BW'(1);
                    end else if (gap_hit) begin
                        byte_cnt_reg <= '0;
                    end
                end
                WDATA: begin
                    if (rx_valid) begin
                        dat_reg      <= dat_shift[DATA_W-1:0];
                        byte_cnt_reg <= last_data ? '0 : byte_cnt_reg + BW'(1);
                    end else if (gap_hit) begin
                        byte_cnt_reg <= '0;
                    end
                end
                BUS:     to_cnt_reg <= bus_done ? '0 : to_cnt_reg + 16'd1;
                default: ;
            endcase
        end
    end

    uart_wb_tx_ser #(
        .DATA_W (DATA_W),
        .CW     (CW)
    ) u_tx_ser (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .start   (bus_done),
        .word    (rsp_word),
        .count   (rsp_count),
        .tx_data (tx_data),
        .tx_load (tx_load),
        .tx_busy (tx_busy),
        .last    (ser_last)
    );
endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench for uart_wb_master (16-bit address/data, BUS_TIMEOUT=8,
// RX_GAP=50). Monitors record bus cycles and transmitted bytes; the main
// sequence compares them against expectations queued with the stimulus.
module tb_uart_wb_master;

    typedef struct packed {
        logic        we;
        logic [15:0] adr;
        logic [15:0] dat;
    } bus_t;
    typedef logic [7:0] byte_q_t[$];

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_busy = 1'b0;
    logic       busy;
    logic       rx_drop;

    uart_wb_master_if #(.ADDR_W(16), .DATA_W(16)) wbif ();

    uart_wb_master #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .BUS_TIMEOUT (8),
        .RX_GAP      (50)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_busy  (tx_busy),
        .wb       (wbif.master),
        .busy     (busy),
        .rx_drop  (rx_drop)
    );

    always #5 CLK = ~CLK;

    // Main-owned state
    int          total = 0;
    int          bad = 0;
    bus_t        bus_exp_q[$];
    logic [7:0]  tx_exp_q[$];
    int          bus_rd = 0;
    int          tx_rd = 0;
    int          ack_delay = 0;
    logic [15:0] slave_rdata = 16'h0000;
    int          late_req = 0;

    // Monitor-owned state
    bus_t        bus_obs_q[$];
    logic [7:0]  tx_obs_q[$];
    int          busy_viol = 0;
    int          cyc_viol = 0;
    int          stb_run = 0;
    int          last_run = 0;
    logic        stb_q = 1'b0;
    int          tx_busy_cnt = 0;
    int          stb_cnt = 0;
    int          late_done = 0;

    // Wishbone slave: ACK after ack_delay STB cycles (0 = never), plus an
    // on-request unconditional ACK pulse used to probe the idle bridge.
    initial begin
        wbif.wb_ack_i = 1'b0;
        wbif.wb_dat_i = 16'h0000;
    end
    always @(negedge CLK) begin
        if (wbif.wb_ack_i) begin
            wbif.wb_ack_i = 1'b0;
        end else if (late_req != late_done) begin
            wbif.wb_ack_i = 1'b1;
            late_done++;
        end else if (wbif.wb_stb_o && ack_delay != 0) begin
            stb_cnt++;
            if (stb_cnt >= ack_delay) begin
                wbif.wb_ack_i = 1'b1;
                wbif.wb_dat_i = slave_rdata;
                stb_cnt = 0;
            end
        end else begin
            stb_cnt = 0;
        end
    end

    // UART transmitter model: busy for 6 cycles after each load.
    always @(negedge CLK) begin
        if (tx_load) begin
            if (tx_busy) busy_viol++;
            tx_obs_q.push_back(tx_data);
            tx_busy_cnt = 6;
        end else if (tx_busy_cnt > 0) begin
            tx_busy_cnt--;
        end
        tx_busy = (tx_busy_cnt > 0);
    end

    // Bus monitor: one record per STB rise, length of each STB pulse.
    always @(negedge CLK) begin
        if (wbif.wb_cyc_o !== wbif.wb_stb_o) cyc_viol++;
        if (wbif.wb_stb_o && !stb_q)
            bus_obs_q.push_back('{we: wbif.wb_we_o, adr: wbif.wb_adr_o,
                                  dat: wbif.wb_we_o ? wbif.wb_dat_o : 16'h0000});
        if (wbif.wb_stb_o) begin
            stb_run++;
        end else if (stb_q) begin
            last_run = stb_run;
            stb_run = 0;
        end
        stb_q = wbif.wb_stb_o;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLK);
        rx_valid = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic send_frame(input byte_q_t bq);
        foreach (bq[i]) send_byte(bq[i]);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic wait_stb(input string tag);
        int n;
        n = 0;
        while (!wbif.wb_stb_o && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_stb_seen"}, wbif.wb_stb_o, 1'b1);
    endtask

    // Compare everything the monitors recorded since the last call.
    task automatic check_txn(input string tag);
        check({tag, "_bus_n"}, bus_obs_q.size() - bus_rd, bus_exp_q.size());
        while (bus_rd < bus_obs_q.size() && bus_exp_q.size() > 0) begin
            check({tag, "_bus"}, bus_obs_q[bus_rd], bus_exp_q.pop_front());
            bus_rd++;
        end
        bus_rd = bus_obs_q.size();
        bus_exp_q.delete();
        check({tag, "_tx_n"}, tx_obs_q.size() - tx_rd, tx_exp_q.size());
        while (tx_rd < tx_obs_q.size() && tx_exp_q.size() > 0) begin
            check({tag, "_tx"}, tx_obs_q[tx_rd], tx_exp_q.pop_front());
            tx_rd++;
        end
        tx_rd = tx_obs_q.size();
        tx_exp_q.delete();
        $display("txn %s: checked (total=%0d bad=%0d)", tag, total, bad);
    endtask

    initial begin
        byte_q_t fq;

        // Reset state
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        check("reset_outputs",
              {wbif.wb_stb_o, wbif.wb_cyc_o, wbif.wb_we_o, busy, tx_load, rx_drop},
              6'b0);
        check("reset_adr_dat", {wbif.wb_adr_o, wbif.wb_dat_o}, 32'h0);

        // Write 0xBEEF to 0x1234, ACK after 3 STB cycles
        ack_delay = 3;
        bus_exp_q.push_back('{we: 1'b1, adr: 16'h1234, dat: 16'hBEEF});
        tx_exp_q.push_back(8'hA5);
        fq = '{8'h80, 8'h12, 8'h34, 8'hBE, 8'hEF};
        send_frame(fq);
        wait_idle("write");
        repeat (10) @(negedge CLK);
        check_txn("write");
        check("write_stb_len", last_run, 3);
        check("write_hold", {wbif.wb_adr_o, wbif.wb_dat_o}, 32'h1234BEEF);

        // Read 0x0010 returning 0x5A3C
        ack_delay = 2;
        slave_rdata = 16'h5A3C;
        bus_exp_q.push_back('{we: 1'b0, adr: 16'h0010, dat: 16'h0000});
        tx_exp_q.push_back(8'h5A);
        tx_exp_q.push_back(8'h3C);
        fq = '{8'h00, 8'h00, 8'h10};
        send_frame(fq);
        wait_idle("read");
        repeat (10) @(negedge CLK);
        check_txn("read");

        // Timeout: no ACK
        ack_delay = 0;
        bus_exp_q.push_back('{we: 1'b0, adr: 16'hABCD, dat: 16'h0000});
        tx_exp_q.push_back(8'hEE);
        fq = '{8'h00, 8'hAB, 8'hCD};
        send_frame(fq);
        wait_idle("timeout");
        repeat (10) @(negedge CLK);
        check_txn("timeout");
        check("timeout_stb_len", last_run, 8);

        // Read after timeout
        ack_delay = 1;
        slave_rdata = 16'h1181;
        bus_exp_q.push_back('{we: 1'b0, adr: 16'h0020, dat: 16'h0000});
        tx_exp_q.push_back(8'h11);
        tx_exp_q.push_back(8'h81);
        fq = '{8'h00, 8'h00, 8'h20};
        send_frame(fq);
        wait_idle("post_to_read");
        repeat (10) @(negedge CLK);
        check_txn("post_to_read");
        check("rx_drop_clear", rx_drop, 1'b0);

        // Stray byte during BUS
        ack_delay = 6;
        slave_rdata = 16'hC3D2;
        bus_exp_q.push_back('{we: 1'b0, adr: 16'h0030, dat: 16'h0000});
        tx_exp_q.push_back(8'hC3);
        tx_exp_q.push_back(8'hD2);
        fq = '{8'h00, 8'h00, 8'h30};
        send_frame(fq);
        wait_stb("stray");
        send_byte(8'h77);
        wait_idle("stray");
        repeat (10) @(negedge CLK);
        check_txn("stray");
        check("stray_rx_drop", rx_drop, 1'b1);

        // Next frame parses from its CMD byte
        ack_delay = 2;
        bus_exp_q.push_back('{we: 1'b1, adr: 16'h0040, dat: 16'h1234});
        tx_exp_q.push_back(8'hA5);
        fq = '{8'h80, 8'h00, 8'h40, 8'h12, 8'h34};
        send_frame(fq);
        wait_idle("after_stray");
        repeat (10) @(negedge CLK);
        check_txn("after_stray");

        // Reset while STB is high, then a late ACK
        ack_delay = 0;
        bus_exp_q.push_back('{we: 1'b0, adr: 16'h0050, dat: 16'h0000});
        fq = '{8'h00, 8'h00, 8'h50};
        send_frame(fq);
        wait_stb("rst");
        repeat (2) @(negedge CLK);
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        check("rst_mid_op",
              {wbif.wb_stb_o, wbif.wb_cyc_o, busy, tx_load, rx_drop}, 5'b0);
        late_req++;
        repeat (12) @(negedge CLK);
        check("rst_late_ack_busy", busy, 1'b0);
        check_txn("rst");

        // Partial frame followed by a long pause
        ack_delay = 1;
        slave_rdata = 16'h7E81;
        fq = '{8'h00, 8'h12};
        send_frame(fq);
        repeat (55) @(negedge CLK);
`ifdef UART_WB_RX_GAP_EN
        check("gap_abort_busy", busy, 1'b0);
        check_txn("gap_abort");
        bus_exp_q.push_back('{we: 1'b0, adr: 16'h1234, dat: 16'h0000});
        tx_exp_q.push_back(8'h7E);
        tx_exp_q.push_back(8'h81);
        fq = '{8'h00, 8'h12, 8'h34};
        send_frame(fq);
`else
        check("gap_wait_busy", busy, 1'b1);
        check_txn("gap_wait");
        bus_exp_q.push_back('{we: 1'b0, adr: 16'h1234, dat: 16'h0000});
        tx_exp_q.push_back(8'h7E);
        tx_exp_q.push_back(8'h81);
        send_byte(8'h34);
`endif
        wait_idle("gap_read");
        repeat (10) @(negedge CLK);
        check_txn("gap_read");

        check("tx_load_while_busy", busy_viol, 0);
        check("cyc_stb_mismatch", cyc_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
